// File: rtl/r0_alu_pkg.sv
// Shared definitions for the r0 ALU stage: opcodes, FSM encoding, default word width.
package r0_alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/r0_shift_add_mul.sv
// Iterative shift-add multiplier datapath: load latches operands, each step adds one
// partial product. prod_o is the accumulator value after the current step.
module r0_shift_add_mul
  import r0_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 last_o,
  output logic [2*WIDTH-1:0]   prod_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [CW-1:0]      cnt_q;

  assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod_o = acc_d;
  assign last_o = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step_i) begin
      acc_q    <= acc_d;
      mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
      cnt_q    <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/r0_alu_stage.sv
// r0 ALU execution stage: single-cycle logic/arithmetic ops plus an optional WIDTH-cycle
// multiply, built only when R0_ALU_MUL_EN is defined (otherwise op 6 is illegal).
module r0_alu_stage
  import r0_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] value1,
  input  logic [WIDTH-1:0] value2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             illegal,
  output logic             state_o
);

  // Handshake: en is a start strobe taken on a rising edge only while busy=0; there is
  // no backpressure and no queueing. done pulses for one cycle whenever result/flags update.

  logic [WIDTH-1:0] res_q, hi_q;
  logic             done_q, z_q, c_q, n_q, ill_q;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_ill, sc_fire;

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_ill = 1'b0;
    case (op)
      OP_ADD:  {sc_c, sc_res} = {1'b0, value1} + {1'b0, value2};
      OP_SUB: begin
        sc_res = value1 - value2;
        sc_c   = (value1 < value2);
      end
      OP_AND:  sc_res = value1 & value2;
      OP_OR:   sc_res = value1 | value2;
      OP_XOR:  sc_res = value1 ^ value2;
      OP_NOT:  sc_res = ~value1;
      default: sc_ill = 1'b1;
    endcase
  end

`ifdef R0_ALU_MUL_EN
  alu_state_e         state_q;
  logic               busy_q;
  logic               mul_start, mul_last;
  logic [2*WIDTH-1:0] mul_prod;

  assign mul_start = en && (state_q == ST_IDLE) && (op == OP_MUL);
  assign sc_fire   = en && (state_q == ST_IDLE) && (op != OP_MUL);
  assign busy      = busy_q;
  assign state_o   = state_q;

  r0_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk_i  (clk),
    .rst_i  (reset),
    .load_i (mul_start),
    .step_i (state_q == ST_MUL),
    .a_i    (value1),
    .b_i    (value2),
    .last_o (mul_last),
    .prod_o (mul_prod)
  );
`else
  assign sc_fire = en;
  assign busy    = 1'b0;
  assign state_o = ST_IDLE;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q  <= '0;
      hi_q   <= '0;
      done_q <= 1'b0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      n_q    <= 1'b0;
      ill_q  <= 1'b0;
`ifdef R0_ALU_MUL_EN
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (sc_fire) begin
        // Unsupported ops report all flags clear, including Z.
        res_q  <= sc_res;
        hi_q   <= '0;
        z_q    <= !sc_ill && (sc_res == '0);
        c_q    <= sc_c;
        n_q    <= !sc_ill && sc_res[WIDTH-1];
        ill_q  <= sc_ill;
        done_q <= 1'b1;
      end
`ifdef R0_ALU_MUL_EN
      case (state_q)
        ST_IDLE: begin
          if (mul_start) begin
            state_q <= ST_MUL;
            busy_q  <= 1'b1;
          end
        end
        ST_MUL: begin
          if (mul_last) begin
            res_q   <= mul_prod[WIDTH-1:0];
            hi_q    <= mul_prod[2*WIDTH-1:WIDTH];
            z_q     <= (mul_prod == '0);
            c_q     <= |mul_prod[2*WIDTH-1:WIDTH];
            n_q     <= mul_prod[2*WIDTH-1];
            ill_q   <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
`endif
    end
  end

  assign done      = done_q;
  assign result    = res_q;
  assign result_hi = hi_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign flag_n    = n_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_r0_alu_stage.sv
// Scoreboard bench for r0_alu_stage; follows R0_ALU_MUL_EN for expected multiply behaviour.
module tb_r0_alu_stage;

  localparam int W  = 8;
  localparam int EW = 2 * W + 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [2:0]   op;
  logic [W-1:0] value1, value2;
  logic         busy, done, flag_z, flag_c, flag_n, illegal, state_o;
  logic [W-1:0] result, result_hi;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  bit busy_exp = 1'b0;

  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  r0_alu_stage #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .op        (op),
    .value1    (value1),
    .value2    (value2),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_n    (flag_n),
    .illegal   (illegal),
    .state_o   (state_o)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required completion", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // reference model: {illegal, N, C, Z, hi, lo}
  function automatic logic [EW-1:0] model(input int o, input int a, input int b);
    int mask = (1 << W) - 1;
    int r = 0, hi = 0, p;
    bit c = 0, ill = 0, z, n;
    case (o)
      0: begin r = (a + b) & mask; c = (a + b) > mask; end
      1: begin r = (a - b) & mask; c = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (~a) & mask;
`ifdef R0_ALU_MUL_EN
      6: begin p = a * b; r = p & mask; hi = p >> W; c = (hi != 0); end
`endif
      default: ill = 1;
    endcase
    z = !ill && (r == 0) && (hi == 0);
    n = !ill && (((o == 6) ? (hi >> (W - 1)) : (r >> (W - 1))) & 1) == 1;
    return {ill, n, c, z, W'(hi), W'(r)};
  endfunction

  // driver: one transaction; MUL transactions optionally poke en / operands while busy
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit poke);
    int lat;
    @(negedge clk);
    en = 1'b1; op = o; value1 = a; value2 = b;
`ifdef R0_ALU_MUL_EN
    lat = (o == 3'd6) ? W + 1 : 1;
`else
    lat = 1;
`endif
    exp_q.push_back(model(int'(o), int'(a), int'(b)));
    exp_cyc_q.push_back(cyc + lat);
    if (lat > 1) begin
      for (int i = 1; i <= W; i++) begin
        @(negedge clk);
        busy_exp = 1'b1;
        en       = poke && (i == 3 || i == W || $urandom_range(0, 3) == 0);
        op       = (poke && i == 3) ? 3'd0 : 3'($urandom_range(0, 7));
        value1   = W'($urandom);
        value2   = W'($urandom);
      end
      @(negedge clk);
      busy_exp = 1'b0;
    end else begin
      @(negedge clk);
    end
    en = 1'b0;
  endtask

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("busy", EW'(busy), EW'(busy_exp));
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", EW'(done), '0);
        end else begin
          chk("done_cycle", EW'(cyc), EW'(exp_cyc_q.pop_front()));
          chk("result", {illegal, flag_n, flag_c, flag_z, result_hi, result}, exp_q.pop_front());
        end
      end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
        chk("missing_done", EW'(done), EW'(1));
        void'(exp_cyc_q.pop_front());
        void'(exp_q.pop_front());
      end
    end
  end

  // main sequence
  initial begin
    reset = 1'b1; en = 1'b0; op = 3'd0; value1 = '0; value2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {illegal, flag_n, flag_c, flag_z, result_hi, result}, '0);
    chk("reset_done_state", EW'({done, state_o}), '0);
    reset = 1'b0;

    issue(3'd0, 8'd3, 8'd2, 1'b0);
    issue(3'd0, 8'd200, 8'd100, 1'b0);
    issue(3'd1, 8'd2, 8'd3, 1'b0);
    issue(3'd4, 8'h5A, 8'h5A, 1'b0);
    issue(3'd5, 8'h0F, 8'h00, 1'b0);
    issue(3'd6, 8'd15, 8'd17, 1'b0);
    issue(3'd6, 8'd255, 8'd255, 1'b0);
    issue(3'd6, 8'd37, 8'd91, 1'b1);
    issue(3'd7, 8'd9, 8'd4, 1'b0);
    issue(3'd6, 8'd3, 8'd2, 1'b0);
    issue(3'd6, 8'd0, 8'd123, 1'b0);

`ifdef R0_ALU_MUL_EN
    // abort a multiply with reset part-way through
    issue(3'd0, 8'd100, 8'd29, 1'b0);
    @(negedge clk);
    en = 1'b1; op = 3'd6; value1 = 8'd9; value2 = 8'd7;
    @(negedge clk);
    en = 1'b0; busy_exp = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1; busy_exp = 1'b0;
    #1;
    chk("abort_outputs", {illegal, flag_n, flag_c, flag_z, result_hi, result}, '0);
    chk("abort_busy_state", EW'({busy, done, state_o}), '0);
    @(negedge clk);
    reset = 1'b0;
    issue(3'd0, 8'd11, 8'd22, 1'b0);
`endif

    repeat (150) begin
      issue(3'($urandom_range(0, 7)),
            ($urandom_range(0, 7) == 0) ? '0 : W'($urandom),
            ($urandom_range(0, 7) == 0) ? '0 : W'($urandom),
            1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("drain", EW'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
